uart_rx_device: RTL and testbench
=================================

Name: uart_rx_device

Overview:
Memory-mapped UART receiver, the input-side counterpart of the CPU's transmit-only uart_device. It deserialises 8N1 frames from the Rx pin into a small FIFO. The CPU reads it through the banked control-address window using the same control_address / control_write / data_in / control_read bus. The CPU top muxes control_read into banked_result for its assigned control page.

Parameters:
CLOCKS_PER_BIT, 104, reset value of the bit-period divisor in clock cycles; must be at least 2.
FIFO_DEPTH, 8, receive FIFO entries; must be a power of two, 2..64.
DEVICE_ID, 16'h5, constant returned at offset 0.

Ports:
clock  input  1  system clock; all state updates on the rising edge.
reset  input  1  asynchronous, active-low; 0 = reset.
control_address  input  4  register offset in the device page.
control_write  input  1  one-cycle write strobe for control_address.
data_in  input  16  write data (the CPU's alu_result).
control_read  output  16  combinational read data for control_address.
Rx  input  1  serial line, idle high, asynchronous to clock.
rx_ready  output  1  high while the FIFO is non-empty.

Behaviour:
- Register map (control_read is combinational from control_address):
  - 0x0: reads DEVICE_ID; writes are ignored.
  - 0x1 STATUS:
    - bit0 data available; bit1 FIFO full.
    - bit2 overrun, sticky; bit3 framing error, sticky.
    - bits[15:8] FIFO count; all other bits read 0.
    - A write with data_in bit2 or bit3 set clears that flag (write-1-to-clear).
  - 0x2 DATA: reads {8'h0, head byte}, or 16'h0 when empty. Any write pops one entry; a pop while empty is ignored.
  - 0x3 DIVISOR: read/write bit period. Reset value is CLOCKS_PER_BIT. A written value below 2 is stored as 2.
  - 0x4..0xF: read 16'h0; writes are ignored.
- Reset (reset=0, asynchronous):
  - FSM returns to IDLE; FIFO is emptied.
  - Both sticky flags clear; divisor returns to CLOCKS_PER_BIT.
  - rx_ready=0; control_read reflects the reset state.
  - A frame in progress when reset asserts is discarded.
- Rx passes through a 2-flop synchroniser (flops reset to 1). All decoding uses the synchronised signal.
- FSM states IDLE, START, DATA, STOP:
  - IDLE: on a synchronised 1->0 transition, latch the divisor into the frame divisor, load the counter with frame_div/2 (integer divide), go to START.
  - START: when the counter expires, sample the line. If 1 (glitch), go to IDLE with no flags set. If 0, reload the counter with frame_div, go to DATA.
  - DATA: sample at each counter expiry, 8 bits LSB first into a shift register, reloading the counter with frame_div each bit. After bit 7, go to STOP.
  - STOP: sample at counter expiry.
    - 1: push the byte and go to IDLE.
    - 0: set framing error, discard the byte, go to IDLE.
    - IDLE re-arms only after the line is seen high (edge detection requires a previous sample of 1).
- A divisor write during a frame affects only the next frame.
- Latency: the pushed byte is visible at DATA, and rx_ready rises, on the clock edge after the stop-bit sample.
- FIFO:
  - Circular buffer with read and write pointers of log2(FIFO_DEPTH)+1 bits; the pointers wrap naturally.
  - Push while full (with no simultaneous pop): the byte is dropped, overrun is set, and FIFO contents are unchanged.
  - Simultaneous pop and push when full: both take effect, the count is unchanged, and overrun is not set.
  - Simultaneous pop and push when empty: the pop is ignored and the push takes effect.
- Simultaneous W1C and a new error event in the same cycle: the set wins.

Decomposition:
- Shared package: register offset constants (DEV_ID=0, STATUS=1, DATA=2, DIVISOR=3), STATUS bit indices, and the rx FSM state encoding (2-bit).
- One natural sub-module: sync_fifo (parameterised WIDTH, DEPTH) with push, pop, full, empty, count, head, and asynchronous active-low reset. The serialiser FSM and register decode stay in uart_rx_device.

Test Plan:
1. CLOCKS_PER_BIT=16. Send frame 0x55; after the stop-bit sample + 1 clock:
   - rx_ready=1, STATUS=16'h0101, DATA reads 16'h0055.
   - Write to 0x2 -> STATUS=16'h0000, rx_ready=0.
2. Drive Rx low for 5 clocks, then high -> FSM returns to IDLE, STATUS stays 16'h0000, no push.
3. Frame 0xA3 with stop bit 0:
   - STATUS bit3=1, count=0.
   - Write 16'h0008 to 0x1 -> STATUS=16'h0000.
   - A following valid frame 0x3C is received correctly after the line goes high.
4. Send bytes 0x01..0x09 without popping:
   - STATUS=16'h0807 (count 8, full, overrun, available).
   - Eight pops return 0x01..0x08 in order; 0x09 is lost.
5. FIFO full; issue a pop in the same cycle as the stop-bit push of 0x77 -> count stays 8, overrun stays 0, last entry is 0x77.
6. Reset:
   - Write 0 to 0x3 -> reads 16'h0002.
   - Assert reset mid-DATA of a frame -> DIVISOR=CLOCKS_PER_BIT, STATUS=0, the partial frame is not delivered, and the next full frame is received normally.

Source files
------------

// File: rtl/uart_rx_device_pkg.sv
// Shared constants for the memory-mapped UART receiver: register offsets,
// STATUS bit positions and the receive FSM state encoding.
package uart_rx_device_pkg;

   localparam logic [3:0] REG_DEV_ID  = 4'h0;
   localparam logic [3:0] REG_STATUS  = 4'h1;
   localparam logic [3:0] REG_DATA    = 4'h2;
   localparam logic [3:0] REG_DIVISOR = 4'h3;

   localparam int STAT_AVAIL   = 0;
   localparam int STAT_FULL    = 1;
   localparam int STAT_OVERRUN = 2;
   localparam int STAT_FRAMING = 3;

   localparam logic [15:0] MIN_DIVISOR = 16'd2;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

endpackage

// File: rtl/uart_rx_device_if.sv
// CPU control-page bus as seen by a banked device: the CPU is the master,
// the device answers combinationally on control_read.
interface uart_rx_device_if;

   logic [3:0]  control_address;
   logic        control_write;
   logic [15:0] data_in;
   logic [15:0] control_read;

   modport master (
      output control_address, control_write, data_in,
      input  control_read
   );

   modport slave (
      input  control_address, control_write, data_in,
      output control_read
   );

endinterface

// File: rtl/uart_rx_device_sync_fifo.sv
// Single-clock circular FIFO; pointers carry one extra wrap bit so that
// full and empty are told apart by the pointer difference alone.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   push,
   input  logic                   pop,
   input  logic [WIDTH-1:0]       din,
   output logic [WIDTH-1:0]       head,
   output logic                   full,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int            AW         = $clog2(DEPTH);
   localparam logic [AW:0]   FULL_COUNT = DEPTH[AW:0];
   localparam logic [AW:0]   PTR_ONE    = {{AW{1'b0}}, 1'b1};

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wr_ptr;
   logic [AW:0]      rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign count   = wr_ptr - rd_ptr;
   assign empty   = (count == '0);
   assign full    = (count == FULL_COUNT);
   assign head    = mem[rd_ptr[AW-1:0]];
   assign do_pop  = pop && !empty;
   // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
         if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clock) begin
      if (do_push) mem[wr_ptr[AW-1:0]] <= din;
   end

endmodule

// File: rtl/uart_rx_device.sv
// Memory-mapped 8N1 UART receiver: synchronises Rx, deserialises frames with
// a mid-bit sampling FSM and queues received bytes for the CPU.
module uart_rx_device
   import uart_rx_device_pkg::*;
#(
   parameter int          CLOCKS_PER_BIT = 104,
   parameter int          FIFO_DEPTH     = 8,
   parameter logic [15:0] DEVICE_ID      = 16'h5
) (
   input  logic            clock,
   input  logic            reset,
   uart_rx_device_if.slave bus,
   input  logic            Rx,
   output logic            rx_ready
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] RESET_DIV = CLOCKS_PER_BIT[15:0];

   rx_state_e   state, state_next;
   logic        rx_meta, rx_sync, rx_prev;
   logic [15:0] div_reg, frame_div, frame_div_next;
   logic [15:0] counter, counter_next;
   logic [2:0]  bit_idx, bit_next;
   logic [7:0]  shift, shift_next;
   logic        expire, stop_ok, stop_bad, push_q;
   logic        overrun, frame_err;
   logic        wr_status, wr_div, pop_req;
   logic        fifo_full, fifo_empty;
   logic [7:0]  fifo_head;
   logic [CW-1:0] fifo_count;

   assign wr_status = bus.control_write && (bus.control_address == REG_STATUS);
   assign wr_div    = bus.control_write && (bus.control_address == REG_DIVISOR);
   assign pop_req   = bus.control_write && (bus.control_address == REG_DATA);
   assign expire    = (counter == 16'd1);

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next     = state;
      counter_next   = counter;
      frame_div_next = frame_div;
      bit_next       = bit_idx;
      shift_next     = shift;
      stop_ok        = 1'b0;
      stop_bad       = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_prev && !rx_sync) begin
               frame_div_next = div_reg;
               counter_next   = div_reg >> 1;
               state_next     = ST_START;
            end
         end
         ST_START: begin
            if (!expire) begin
               counter_next = counter - 16'd1;
            end else if (rx_sync) begin
               state_next = ST_IDLE;
            end else begin
               counter_next = frame_div;
               bit_next     = 3'd0;
               state_next   = ST_DATA;
            end
         end
         ST_DATA: begin
            if (!expire) begin
               counter_next = counter - 16'd1;
            end else begin
               shift_next   = {rx_sync, shift[7:1]};
               counter_next = frame_div;
               bit_next     = bit_idx + 3'd1;
               if (bit_idx == 3'd7) state_next = ST_STOP;
            end
         end
         ST_STOP: begin
            if (!expire) begin
               counter_next = counter - 16'd1;
            end else begin
               stop_ok    = rx_sync;
               stop_bad   = !rx_sync;
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state     <= ST_IDLE;
         rx_meta   <= 1'b1;
         rx_sync   <= 1'b1;
         rx_prev   <= 1'b1;
         frame_div <= RESET_DIV;
         counter   <= '0;
         bit_idx   <= '0;
         shift     <= '0;
         push_q    <= 1'b0;
      end else begin
         state     <= state_next;
         rx_meta   <= Rx;
         rx_sync   <= rx_meta;
         rx_prev   <= rx_sync;
         frame_div <= frame_div_next;
         counter   <= counter_next;
         bit_idx   <= bit_next;
         shift     <= shift_next;
         // The byte lands in the FIFO one edge after its stop bit is sampled.
         push_q    <= stop_ok;
      end
   end

   // Sticky flags: a new error event in the same cycle beats the clear.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         overrun   <= 1'b0;
         frame_err <= 1'b0;
         div_reg   <= RESET_DIV;
      end else begin
         if (push_q && fifo_full && !pop_req)
            overrun <= 1'b1;
         else if (wr_status && bus.data_in[STAT_OVERRUN])
            overrun <= 1'b0;

         if (stop_bad)
            frame_err <= 1'b1;
         else if (wr_status && bus.data_in[STAT_FRAMING])
            frame_err <= 1'b0;

         if (wr_div)
            div_reg <= (bus.data_in < MIN_DIVISOR) ? MIN_DIVISOR : bus.data_in;
      end
   end

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clock (clock),
      .reset (reset),
      .push  (push_q),
      .pop   (pop_req),
      .din   (shift),
      .head  (fifo_head),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (fifo_count)
   );

   assign rx_ready = !fifo_empty;

   always_comb begin
      bus.control_read = '0;
      case (bus.control_address)
         REG_DEV_ID:  bus.control_read = DEVICE_ID;
         REG_STATUS:  bus.control_read = {8'(fifo_count), 4'h0, frame_err, overrun,
                                          fifo_full, !fifo_empty};
         REG_DATA:    bus.control_read = fifo_empty ? 16'h0 : {8'h00, fifo_head};
         REG_DIVISOR: bus.control_read = div_reg;
         default:     bus.control_read = '0;
      endcase
   end

endmodule

// File: tb/tb_uart_rx_device.sv
// Directed-plus-random bench for uart_rx_device; expected register values come
// from a byte-queue model of the receiver built from its programmer's view.
module tb_uart_rx_device;
   import uart_rx_device_pkg::*;

   localparam int D            = 16;
   localparam int DEPTH        = 8;
   localparam int FRAME_CYCLES = 10 * D;
   // Negedge index (from the frame's first negedge) just after the FIFO push edge.
   localparam int PUSH_EDGE    = 4 + D / 2 + 9 * D;

   logic clock = 1'b0;
   logic reset = 1'b0;
   logic Rx    = 1'b1;
   logic rx_ready;

   uart_rx_device_if bus();

   uart_rx_device #(
      .CLOCKS_PER_BIT (D),
      .FIFO_DEPTH     (DEPTH),
      .DEVICE_ID      (16'h5)
   ) dut (
      .clock    (clock),
      .reset    (reset),
      .bus      (bus),
      .Rx       (Rx),
      .rx_ready (rx_ready)
   );

   always #5 clock = ~clock;

   int          n_checks = 0;
   int          n_fails  = 0;
   logic [7:0]  mq[$];
   bit          m_ovr;
   bit          m_ferr;
   logic [15:0] m_div;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fails++;
         $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] exp_status();
      logic [15:0] s = '0;
      s[15:8] = 8'(mq.size());
      s[3]    = m_ferr;
      s[2]    = m_ovr;
      s[1]    = (mq.size() == DEPTH);
      s[0]    = (mq.size() != 0);
      return s;
   endfunction

   function automatic logic [15:0] exp_data();
      return (mq.size() != 0) ? {8'h00, mq[0]} : 16'h0000;
   endfunction

   function automatic logic frame_bit(input logic [7:0] b, input logic stop, input int c);
      int k = c / D;
      if (k == 0) return 1'b0;
      if (k <= 8) return b[k-1];
      return stop;
   endfunction

   task automatic model_frame(input logic [7:0] b, input logic stop, input bit pop);
      bit was_full = (mq.size() == DEPTH);
      if (pop && mq.size() != 0) void'(mq.pop_front());
      if (!stop)                m_ferr = 1'b1;
      else if (was_full && !pop) m_ovr = 1'b1;
      else                      mq.push_back(b);
   endtask

   task automatic model_pop();
      if (mq.size() != 0) void'(mq.pop_front());
   endtask

   task automatic rd(input logic [3:0] a, output logic [15:0] v);
      @(negedge clock);
      bus.control_address = a;
      bus.control_write   = 1'b0;
      #1 v = bus.control_read;
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      @(negedge clock);
      bus.control_address = a;
      bus.data_in         = d;
      bus.control_write   = 1'b1;
      @(negedge clock);
      bus.control_write   = 1'b0;
   endtask

   task automatic check_regs(input string tag);
      logic [15:0] v;
      rd(REG_STATUS, v);
      check({tag, "_status"}, v, exp_status());
      rd(REG_DATA, v);
      check({tag, "_data"}, v, exp_data());
      check({tag, "_rx_ready"}, {15'h0, rx_ready}, {15'h0, (mq.size() != 0)});
   endtask

   // One full 8N1 frame; optionally pops DATA on the push edge and checks
   // rx_ready on either side of it (only meaningful for an empty FIFO).
   task automatic send_frame(input logic [7:0] b, input logic stop, input bit pop,
                             input bit chk_lat);
      for (int c = 0; c < FRAME_CYCLES; c++) begin
         @(negedge clock);
         if (chk_lat && c == PUSH_EDGE - 1)
            check("latency_before_push", {15'h0, rx_ready}, 16'h0000);
         if (chk_lat && c == PUSH_EDGE)
            check("latency_after_push", {15'h0, rx_ready}, 16'h0001);
         Rx                  = frame_bit(b, stop, c);
         bus.control_address = REG_DATA;
         bus.control_write   = pop && (c == PUSH_EDGE - 1);
      end
      @(negedge clock);
      Rx                = 1'b1;
      bus.control_write = 1'b0;
      repeat (4) @(negedge clock);
      model_frame(b, stop, pop);
   endtask

   initial begin
      logic [15:0] v;
      logic [7:0]  b;
      logic        stop;
      bit          pop;

      bus.control_address = '0;
      bus.control_write   = 1'b0;
      bus.data_in         = '0;
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      m_div  = 16'(D);
      repeat (3) @(negedge clock);
      reset = 1'b1;
      repeat (2) @(negedge clock);

      // Reset state and the fixed registers
      check_regs("reset");
      rd(REG_DEV_ID, v);  check("dev_id", v, 16'h0005);
      rd(REG_DIVISOR, v); check("divisor_reset", v, m_div);
      wr(REG_DEV_ID, 16'hFFFF);
      rd(REG_DEV_ID, v);  check("dev_id_write_ignored", v, 16'h0005);
      wr(4'hF, 16'hFFFF);
      rd(4'hF, v);        check("unmapped_reads_zero", v, 16'h0000);

      // 1: single frame, then pop
      send_frame(8'h55, 1'b1, 1'b0, 1'b1);
      check_regs("t1_frame");
      wr(REG_DATA, 16'h0000);
      model_pop();
      check_regs("t1_popped");
      wr(REG_DATA, 16'h0000);
      check_regs("t1_pop_empty");

      // 2: short low glitch on the line
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         Rx = 1'b0;
      end
      @(negedge clock);
      Rx = 1'b1;
      repeat (30) @(negedge clock);
      check_regs("t2_glitch");

      // 3: framing error, clear it, then a clean frame
      send_frame(8'hA3, 1'b0, 1'b0, 1'b0);
      check_regs("t3_ferr");
      wr(REG_STATUS, 16'h0008);
      m_ferr = 1'b0;
      check_regs("t3_cleared");
      send_frame(8'h3C, 1'b1, 1'b0, 1'b1);
      check_regs("t3_good");
      wr(REG_DATA, 16'h0000);
      model_pop();

      // 4: overflow by one
      for (int i = 1; i <= 9; i++) send_frame(8'(i), 1'b1, 1'b0, 1'b0);
      check_regs("t4_full");
      for (int i = 0; i < 8; i++) begin
         rd(REG_DATA, v);
         check("t4_pop_order", v, exp_data());
         wr(REG_DATA, 16'h0000);
         model_pop();
      end
      check_regs("t4_drained");
      wr(REG_STATUS, 16'h0004);
      m_ovr = 1'b0;
      check_regs("t4_ovr_cleared");

      // 5: pop and push together on a full FIFO
      for (int i = 0; i < DEPTH; i++) send_frame(8'($urandom), 1'b1, 1'b0, 1'b0);
      check_regs("t5_full");
      send_frame(8'h77, 1'b1, 1'b1, 1'b0);
      check_regs("t5_pop_push");
      for (int i = 0; i < DEPTH; i++) begin
         rd(REG_DATA, v);
         check("t5_drain", v, exp_data());
         wr(REG_DATA, 16'h0000);
         model_pop();
      end
      check_regs("t5_empty");

      // Random frames, stop bits, same-edge pops and flag clears
      for (int i = 0; i < 14; i++) begin
         b    = 8'($urandom);
         stop = ($urandom_range(0, 4) != 0);
         pop  = ($urandom_range(0, 2) == 0);
         send_frame(b, stop, pop, 1'b0);
         check_regs("rand_frame");
         if ($urandom_range(0, 1) == 1) begin
            wr(REG_STATUS, 16'h000C);
            m_ovr  = 1'b0;
            m_ferr = 1'b0;
            check_regs("rand_w1c");
         end
      end

      // 6: divisor clamp, then reset in the middle of a frame
      wr(REG_DIVISOR, 16'h0000);
      rd(REG_DIVISOR, v); check("t6_div_clamp", v, 16'h0002);
      wr(REG_DIVISOR, 16'(D));
      send_frame(8'h11, 1'b1, 1'b0, 1'b0);
      wr(REG_DIVISOR, 16'd40);
      rd(REG_DIVISOR, v); check("t6_div_40", v, 16'd40);
      for (int c = 0; c < 70; c++) begin
         @(negedge clock);
         Rx = frame_bit(8'hE7, 1'b1, c);
      end
      reset = 1'b0;
      Rx    = 1'b1;
      repeat (3) @(negedge clock);
      reset = 1'b1;
      mq.delete();
      m_ovr  = 1'b0;
      m_ferr = 1'b0;
      m_div  = 16'(D);
      repeat (5) @(negedge clock);
      rd(REG_DIVISOR, v); check("t6_div_after_reset", v, m_div);
      check_regs("t6_after_reset");
      repeat (3 * FRAME_CYCLES / 2) @(negedge clock);
      check_regs("t6_no_partial");
      send_frame(8'h5A, 1'b1, 1'b0, 1'b1);
      check_regs("t6_next_frame");

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
